// File: rtl/halfduplex_pin_master.sv
// Open-drain single-wire bus master: bus reset/presence detect and LSB-first
// byte write/read using fixed-length time slots on one tri-stated pin.
module halfduplex_pin_master #(
  parameter int unsigned T_SLOT   = 60,
  parameter int unsigned T_LOW0   = 55,
  parameter int unsigned T_LOW1   = 5,
  parameter int unsigned T_SAMPLE = 12,
  parameter int unsigned T_RSTL   = 480,
  parameter int unsigned T_PDET   = 550,
  parameter int unsigned T_RST    = 960
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD,
  input  logic [7:0] WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RDATA,
  output logic       PRESENCE,
  output logic       BUSY,
  output logic       PAD_I,
  output logic       PAD_T,
  input  logic       PAD_O
);

  localparam int unsigned CW = $clog2(T_RST + 1);

  typedef enum logic [2:0] {IDLE, RSTLOW, RSTWAIT, SLOT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    wbuf;
  logic [7:0]    rbuf;
  logic          is_read;
  logic [1:0]    pin_sync;
  logic          pin;
  logic          accept;
  logic          slot_end;
  logic [CW-1:0] low_len;

  assign pin      = pin_sync[1];
  assign accept   = CMD_VALID && (state == IDLE);
  assign slot_end = (cnt == CW'(T_SLOT - 1));
  assign low_len  = (is_read || wbuf[bit_idx]) ? CW'(T_LOW1) : CW'(T_LOW0);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (CMD)
            2'b00:        state_nxt = RSTLOW;
            2'b01, 2'b10: state_nxt = SLOT;
            default:      state_nxt = DONE;
          endcase
        end
      end
      RSTLOW:  if (cnt == CW'(T_RSTL - 1)) state_nxt = RSTWAIT;
      RSTWAIT: if (cnt == CW'(T_RST - 1))  state_nxt = DONE;
      SLOT:    if (slot_end && (bit_idx == 3'd7)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state == IDLE);
    BUSY      = (state != IDLE);
    RSP_VALID = (state == DONE);
    PAD_I     = 1'b0;
    PAD_T     = 1'b1;
    unique case (state)
      RSTLOW:  PAD_T = 1'b0;
      SLOT:    PAD_T = (cnt >= low_len);
      default: PAD_T = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pin_sync <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
      is_read  <= 1'b0;
      RDATA    <= '0;
      PRESENCE <= 1'b0;
    end else begin
      pin_sync <= {pin_sync[0], PAD_O};
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (accept) begin
            wbuf    <= WDATA;
            is_read <= (CMD == 2'b10);
            rbuf    <= '0;
          end
        end
        RSTLOW: cnt <= cnt + 1'b1;
        RSTWAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(T_PDET)) PRESENCE <= ~pin;
        end
        SLOT: begin
          if (is_read && (cnt == CW'(T_SAMPLE))) rbuf[bit_idx] <= pin;
          if (slot_end) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            // Last sample was taken earlier in slot 7, so rbuf is complete
            // here; loading now makes RDATA valid during the DONE cycle.
            if ((bit_idx == 3'd7) && is_read) RDATA <= rbuf;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_halfduplex_pin_master.sv
// Directed bench for halfduplex_pin_master with short timing parameters and
// an open-drain responder model on the pin.
module tb_halfduplex_pin_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b11;
  logic [7:0] wdata = '0;
  logic       rsp_valid;
  logic [7:0] rdata;
  logic       presence;
  logic       busy;
  logic       pad_i;
  logic       pad_t;
  logic       pad_o;
  logic       resp_low = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic pt_log [0:127];

  // Wired-AND of master and responder, pulled up otherwise.
  assign pad_o = (pad_t || pad_i) && !resp_low;

  always #5 clk = ~clk;

  halfduplex_pin_master #(
    .T_SLOT(8), .T_LOW0(6), .T_LOW1(1), .T_SAMPLE(3),
    .T_RSTL(20), .T_PDET(26), .T_RST(40)
  ) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD(cmd), .WDATA(wdata), .RSP_VALID(rsp_valid), .RDATA(rdata),
    .PRESENCE(presence), .BUSY(busy), .PAD_I(pad_i), .PAD_T(pad_t),
    .PAD_O(pad_o)
  );

  function automatic logic responder(input int mode, input int k);
    int s;
    s = (k - 1) / 8;
    case (mode)
      1: return (s == 1) || (s == 3);
      2: return (k - 1 >= 22) && (k - 1 <= 30);
      default: return 1'b0;
    endcase
  endfunction

  // Issues one command, then scrambles CMD/WDATA while it runs; cycle k is
  // the k-th cycle after the accept edge.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input int mode,
                         input int maxcyc, output int rsp_at, output int rsp_cnt,
                         output logic [7:0] rd_at);
    rsp_at = -1; rsp_cnt = 0; rd_at = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = ~c; wdata = ~wd;
    for (int k = 1; k <= maxcyc; k++) begin
      resp_low = responder(mode, k);
      pt_log[k] = pad_t;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_at < 0) begin
          rsp_at = k;
          rd_at  = rdata;
        end
      end
      @(posedge clk); #1;
    end
    resp_low = 1'b0;
  endtask

  task automatic check_slots(input string name, input logic [7:0] b);
    logic [7:0] got, exp;
    int l;
    for (int s = 0; s < 8; s++) begin
      l = b[s] ? 1 : 6;
      for (int j = 0; j < 8; j++) begin
        got[j] = pt_log[1 + 8*s + j];
        exp[j] = (j >= l);
      end
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s slot%0d pad_t got=%b exp=%b", name, s, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (pad_t !== 1'b1)     begin n_fail++; $display("FAIL reset pad_t got=%b exp=1", pad_t); end
    n_checks++; if (pad_i !== 1'b0)     begin n_fail++; $display("FAIL reset pad_i got=%b exp=0", pad_i); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy got=%b exp=0", busy); end
    n_checks++; if (rdata !== 8'h00)    begin n_fail++; $display("FAIL reset rdata got=%h exp=00", rdata); end
    n_checks++; if (presence !== 1'b0)  begin n_fail++; $display("FAIL reset presence got=%b exp=0", presence); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    int at, cnt; logic [7:0] rd;
    run_cmd(2'b01, 8'hA5, 0, 70, at, cnt, rd);
    check_slots("write_a5", 8'hA5);
    n_checks++; if (at !== 65)  begin n_fail++; $display("FAIL write rsp_cycle got=%0d exp=65", at); end
    n_checks++; if (cnt !== 1)  begin n_fail++; $display("FAIL write rsp_count got=%0d exp=1", cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    int at, cnt; logic [7:0] rd;
    run_cmd(2'b10, 8'h00, 1, 70, at, cnt, rd);
    n_checks++; if (at !== 65)     begin n_fail++; $display("FAIL read rsp_cycle got=%0d exp=65", at); end
    n_checks++; if (rd !== 8'hF5)  begin n_fail++; $display("FAIL read rdata got=%h exp=f5", rd); end
    n_checks++; if (rdata !== 8'hF5) begin n_fail++; $display("FAIL read rdata_held got=%h exp=f5", rdata); end
    check_slots("read", 8'hFF);
  endtask

  task automatic test_presence(input int mode, input logic exp_p);
    int at, cnt, lows; logic [7:0] rd;
    run_cmd(2'b00, 8'h00, mode, 45, at, cnt, rd);
    lows = 0;
    for (int k = 1; k <= 45; k++) if (pt_log[k] === 1'b0) lows++;
    n_checks++; if (lows !== 20) begin n_fail++; $display("FAIL busrst low_cycles got=%0d exp=20", lows); end
    n_checks++; if (pt_log[20] !== 1'b0 || pt_log[21] !== 1'b1)
      begin n_fail++; $display("FAIL busrst low_edge got=%b%b exp=01", pt_log[20], pt_log[21]); end
    n_checks++; if (at !== 41) begin n_fail++; $display("FAIL busrst rsp_cycle got=%0d exp=41", at); end
    n_checks++; if (presence !== exp_p)
      begin n_fail++; $display("FAIL presence mode%0d got=%b exp=%b", mode, presence, exp_p); end
  endtask

  task automatic test_abort();
    int at, cnt; logic [7:0] rd;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b01; wdata = 8'hA5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (26) begin @(posedge clk); #1; end
    n_checks++; if (pad_t !== 1'b0) begin n_fail++; $display("FAIL abort mid_slot pad_t got=%b exp=0", pad_t); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (pad_t !== 1'b1)     begin n_fail++; $display("FAIL abort pad_t got=%b exp=1", pad_t); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (presence !== 1'b0)  begin n_fail++; $display("FAIL abort presence got=%b exp=0", presence); end
    n_checks++; if (rdata !== 8'h00)    begin n_fail++; $display("FAIL abort rdata got=%h exp=00", rdata); end
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL abort stray_rsp got=%0d exp=0", cnt); end
    run_cmd(2'b01, 8'h5A, 0, 70, at, cnt, rd);
    check_slots("write_5a", 8'h5A);
    n_checks++; if (at !== 65) begin n_fail++; $display("FAIL abort next_write rsp_cycle got=%0d exp=65", at); end
  endtask

  task automatic test_noop();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b11;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL noop c1 rsp_valid got=%b exp=1", rsp_valid); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL noop c1 cmd_ready got=%b exp=0", cmd_ready); end
    n_checks++; if (pad_t !== 1'b1)     begin n_fail++; $display("FAIL noop c1 pad_t got=%b exp=1", pad_t); end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL noop c2 rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL noop c2 cmd_ready got=%b exp=1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL noop c3 rsp_valid got=%b exp=1", rsp_valid); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noop c4 busy got=%b exp=0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_presence(2, 1'b1);
    test_presence(0, 1'b0);
    test_presence(2, 1'b1);
    test_abort();
    test_noop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/halfduplex_pin_master.md
HALFDUPLEX_PIN_MASTER -- requirements
Module: halfduplex_pin_master

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  T_SLOT   60   bit-slot length in CLK cycles
  T_LOW0   55   low time for a write-0 slot
  T_LOW1   5    low time for a write-1 or read slot
  T_SAMPLE 12   slot cycle index at which a read bit is sampled
  T_RSTL   480  reset-pulse low time
  T_PDET   550  cycle index (from reset start) at which presence is sampled
  T_RST    960  total reset/presence sequence length
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  CLK        input  1  single clock, rising edge
  RST        input  1  synchronous, active-high reset
  CMD_VALID  input  1  command request
  CMD_READY  output 1  command accepted when high together with CMD_VALID
  CMD        input  2  00 bus reset/presence, 01 write byte, 10 read byte, 11 no-op
  WDATA      input  8  byte to write, captured at accept
  RSP_VALID  output 1  one-cycle completion pulse
  RDATA      output 8  byte read, valid while RSP_VALID is high and held afterwards
  PRESENCE   output 1  presence result of the last bus reset (1 = device answered)
  BUSY       output 1  high in every state except IDLE
  PAD_I      output 1  drive value to the tri-state pad buffer; constant 0 (open-drain)
  PAD_T      output 1  pad tristate control; 0 = drive low, 1 = release (high-Z)
  PAD_O      input  1  pin level read back from the pad buffer

Function
REQ-003 SHALL pass PAD_O through a 2-flop synchronizer; all samples SHALL use the synchronized value.
REQ-004 SHALL implement the states IDLE, RSTLOW, RSTWAIT, SLOT and DONE.
REQ-005 CMD_READY SHALL be 1 only in IDLE; a command SHALL be accepted on the edge where CMD_VALID and CMD_READY are both 1.
REQ-006 Accept transitions: CMD=00 -> RSTLOW; CMD=01/10 -> SLOT with bit index 0; CMD=11 -> DONE.
REQ-007 A cycle counter SHALL start at 0 in the first cycle after accept and increment each cycle.
REQ-008 RSTLOW: PAD_T=0 for counter 0..T_RSTL-1, then RSTWAIT with PAD_T=1.
REQ-009 RSTWAIT: at counter==T_PDET, PRESENCE SHALL be set to the inverse of the synchronized pin; at counter==T_RST-1 the block SHALL go to DONE.
REQ-010 SLOT: PAD_T=0 for slot cycles 0..L-1, then 1 through T_SLOT-1.
  L = T_LOW1 for a read slot or a write-1 slot; L = T_LOW0 for a write-0 slot.
REQ-011 Bit order SHALL be LSB first; the slot counter SHALL reset to 0 at each new slot.
REQ-012 Read: at slot cycle T_SAMPLE the synchronized pin SHALL be shifted into the RDATA shift register at bit position index.
REQ-013 After slot 7 cycle T_SLOT-1 the block SHALL go to DONE; slots SHALL be back-to-back with no gap.
REQ-014 DONE SHALL last exactly one cycle: RSP_VALID=1 and RDATA updated (reads only), then IDLE.
  Write byte: RSP_VALID asserts 8*T_SLOT+1 cycles after accept.
  Reset: RSP_VALID asserts T_RST+1 cycles after accept.
  No-op: RSP_VALID asserts 1 cycle after accept.
REQ-015 WDATA and CMD SHALL be ignored outside the accept edge; changing them mid-operation SHALL have no effect.
REQ-016 Parameter constraints (not checked in RTL):
  T_LOW1 < T_SAMPLE < T_SLOT; T_LOW0 < T_SLOT; T_RSTL < T_PDET < T_RST; counter width >= clog2(T_RST).

Reset
REQ-017 On an RST edge the block SHALL enter IDLE from any state, including mid-slot and mid-reset-pulse.
REQ-018 After that RST edge: PAD_T=1, PAD_I=0, CMD_READY=1, RSP_VALID=0, BUSY=0, RDATA=0x00, PRESENCE=0, counters and synchronizer cleared.
REQ-019 A command aborted by RST SHALL produce no RSP_VALID.

Verification (T_SLOT=8, T_LOW0=6, T_LOW1=1, T_SAMPLE=3, T_RSTL=20, T_PDET=26, T_RST=40; pin pulled up unless driven)
REQ-020 Write 0xA5 -> PAD_T low runs of 1,6,1,6,6,1,6,1 cycles at 8-cycle pitch; RSP_VALID 65 cycles after accept; BUSY low after.
REQ-021 Read with responder holding the pin low in slots 1 and 3 -> RDATA=0xF5 at RSP_VALID, 65 cycles after accept.
REQ-022 Reset, responder low during cycles 22..30 -> PAD_T low for 20 cycles; PRESENCE=1; RSP_VALID at cycle 41.
REQ-023 Reset with no responder -> PRESENCE=0.
REQ-024 RST asserted during slot 3 of a write -> PAD_T=1 and CMD_READY=1 the next cycle; no RSP_VALID; next write completes normally.
REQ-025 CMD=11 -> no PAD_T activity; RSP_VALID 1 cycle after accept; CMD_VALID held high during BUSY -> no second accept until IDLE.
